// File: rtl/traffic_pkg.sv
// Shared types and transition rule for the traffic light controller and its
// independent lamp monitor.
package traffic_pkg;

   typedef enum logic [2:0] {
      PH_AG      = 3'd0,
      PH_AY      = 3'd1,
      PH_BG      = 3'd2,
      PH_BY      = 3'd3,
      PH_FLASH   = 3'd4,
      PH_DARK    = 3'd5,
      PH_ILLEGAL = 3'd7
   } phase_t;

   typedef enum logic [2:0] {
      FLT_NONE     = 3'd0,
      FLT_CONFLICT = 3'd1,
      FLT_ILLEGAL  = 3'd2,
      FLT_SEQUENCE = 3'd3,
      FLT_STUCK    = 3'd4,
      FLT_MODE     = 3'd5
   } fault_t;

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_FAULT
   } mon_state_t;

   function automatic logic is_day(input phase_t p);
      return (p == PH_AG) || (p == PH_AY) || (p == PH_BG) || (p == PH_BY);
   endfunction

   // True when the lamps may go from prev to cur in one sample.
   function automatic logic legal_next(input phase_t prev, input phase_t cur);
      logic ok;
      ok = 1'b0;
      case (prev)
         PH_AG:    ok = (cur == PH_AY) || (cur == PH_FLASH);
         PH_AY:    ok = (cur == PH_BG) || (cur == PH_FLASH);
         PH_BG:    ok = (cur == PH_BY) || (cur == PH_FLASH);
         PH_BY:    ok = (cur == PH_AG) || (cur == PH_FLASH);
         PH_FLASH: ok = (cur == PH_DARK) || (cur == PH_AG);
         PH_DARK:  ok = (cur == PH_FLASH) || (cur == PH_AG);
         default:  ok = 1'b0;
      endcase
      return ok || (prev == cur);
   endfunction

endpackage

// File: rtl/traffic_pattern_decode.sv
// Combinational decode of the six lamp lines into a displayed pattern and a
// conflict flag (opposing go lamps or several lamps lit on one head).
module traffic_pattern_decode
   import traffic_pkg::*;
(
   input  logic [2:0] lamp_a,   // {green, yellow, red}
   input  logic [2:0] lamp_b,   // {green, yellow, red}
   output phase_t     phase,
   output logic       conflict
);

   logic a_go, b_go, a_multi, b_multi;

   always_comb begin
      // NOTE: default assigned first so every path drives phase; no latch.
      phase = PH_ILLEGAL;
      case ({lamp_a, lamp_b})
         6'b100_001: phase = PH_AG;
         6'b010_001: phase = PH_AY;
         6'b001_100: phase = PH_BG;
         6'b001_010: phase = PH_BY;
         6'b010_010: phase = PH_FLASH;
         6'b000_000: phase = PH_DARK;
         default:    phase = PH_ILLEGAL;
      endcase
   end

   assign a_go    = lamp_a[2] | lamp_a[1];
   assign b_go    = lamp_b[2] | lamp_b[1];
   assign a_multi = (lamp_a[2] & lamp_a[1]) | (lamp_a[2] & lamp_a[0]) | (lamp_a[1] & lamp_a[0]);
   assign b_multi = (lamp_b[2] & lamp_b[1]) | (lamp_b[2] & lamp_b[0]) | (lamp_b[1] & lamp_b[0]);

   // Both heads yellow only is the night flash pattern, not a conflict.
   assign conflict = (a_go & b_go & (phase != PH_FLASH)) | a_multi | b_multi;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor beside the traffic light controller: checks pattern order,
// dwell and day/night consistency, latching the first fault until cleared.
module traffic_conflict_monitor
   import traffic_pkg::*;
#(
   parameter int MAX_DWELL = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             modo,
   input  logic             A_green,
   input  logic             A_yellow,
   input  logic             A_red,
   input  logic             B_green,
   input  logic             B_yellow,
   input  logic             B_red,
   input  logic             clear_fault,
   output logic [2:0]       phase,
   output logic             phase_valid,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int DW_W = $clog2(MAX_DWELL + 2);
   localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MAX_DWELL);
   localparam logic [DW_W-1:0] DWELL_SAT = DW_W'(MAX_DWELL + 1);

   logic [5:0]       lamp_q;
   logic             lamp_vld;
   logic             modo_q, modo_qq;
   mon_state_t       state, state_d;
   phase_t           prev, prev_d;
   logic [DW_W-1:0]  dwell, dwell_d;
   phase_t           phase_r;
   logic             phase_valid_r;
   logic             fault_r, fault_d;
   fault_t           code_r, code_d;
   logic [CNT_W-1:0] count_r, count_d;

   phase_t cur;
   logic   cur_conflict;
   logic   mode_bad;
   fault_t flt;

   traffic_pattern_decode u_decode (
      .lamp_a   (lamp_q[5:3]),
      .lamp_b   (lamp_q[2:0]),
      .phase    (cur),
      .conflict (cur_conflict)
   );

   // modo_qq lags the lamp sample by one, matching the controller's response time.
   assign mode_bad = is_day(cur) ? modo_qq
                   : ((cur == PH_FLASH) || (cur == PH_DARK)) ? ~modo_qq : 1'b0;

   always_comb begin
      flt = FLT_NONE;
      if (cur_conflict)                              flt = FLT_CONFLICT;
      else if (cur == PH_ILLEGAL)                    flt = FLT_ILLEGAL;
      else if (!legal_next(prev, cur))               flt = FLT_SEQUENCE;
      else if (mode_bad)                             flt = FLT_MODE;
      else if ((cur == prev) && (dwell >= DWELL_MAX)) flt = FLT_STUCK;
   end

   always_comb begin
      state_d = state;
      prev_d  = prev;
      dwell_d = dwell;
      fault_d = fault_r;
      code_d  = code_r;
      count_d = count_r;
      case (state)
         S_INIT: if (lamp_vld) begin
            if ((flt == FLT_CONFLICT) || (flt == FLT_ILLEGAL)) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
               code_d  = flt;
            end else begin
               state_d = S_RUN;
               prev_d  = cur;
               dwell_d = DW_W'(1);
            end
         end
         S_RUN: if (lamp_vld) begin
            if (flt != FLT_NONE) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
               code_d  = flt;
            end else begin
               if ((prev == PH_BY) && (cur == PH_AG)) count_d = count_r + CNT_W'(1);
               if (cur != prev)              dwell_d = DW_W'(1);
               else if (dwell != DWELL_SAT)  dwell_d = dwell + DW_W'(1);
               prev_d = cur;
            end
         end
         S_FAULT: if (clear_fault) begin
            state_d = S_INIT;
            fault_d = 1'b0;
            code_d  = FLT_NONE;
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_INIT;
         prev    <= PH_AG;
         dwell   <= '0;
         fault_r <= 1'b0;
         code_r  <= FLT_NONE;
         count_r <= '0;
      end else begin
         state   <= state_d;
         prev    <= prev_d;
         dwell   <= dwell_d;
         fault_r <= fault_d;
         code_r  <= code_d;
         count_r <= count_d;
      end
   end

   // lamp_vld keeps the reset value of lamp_q (which reads as DARK) out of the checks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lamp_q        <= '0;
         lamp_vld      <= 1'b0;
         modo_q        <= 1'b0;
         modo_qq       <= 1'b0;
         phase_r       <= PH_AG;
         phase_valid_r <= 1'b0;
      end else begin
         // NOTE: non-blocking so modo_qq takes the old modo_q on this same edge.
         lamp_q   <= {A_green, A_yellow, A_red, B_green, B_yellow, B_red};
         lamp_vld <= 1'b1;
         modo_q   <= modo;
         modo_qq  <= modo_q;
         if (lamp_vld) begin
            phase_r       <= cur;
            phase_valid_r <= (cur != PH_ILLEGAL);
         end
      end
   end

   assign phase       = phase_r;
   assign phase_valid = phase_valid_r;
   assign fault       = fault_r;
   assign fault_code  = code_r;
   assign cycle_count = count_r;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed vector table for the scenario
// list, hand sequence for mid-stream reset, then random lamps against a model.
module tb_traffic_conflict_monitor;

   localparam int MAX_DWELL = 8;
   localparam int CNT_W     = 8;

   localparam logic [5:0] L_AG = 6'b100_001;
   localparam logic [5:0] L_AY = 6'b010_001;
   localparam logic [5:0] L_BG = 6'b001_100;
   localparam logic [5:0] L_BY = 6'b001_010;
   localparam logic [5:0] L_FL = 6'b010_010;
   localparam logic [5:0] L_DK = 6'b000_000;
   localparam logic [5:0] L_CF = 6'b100_100;

   logic clk = 1'b0;
   logic reset;
   logic modo, clear_fault;
   logic A_green, A_yellow, A_red, B_green, B_yellow, B_red;
   logic [2:0]       phase;
   logic             phase_valid, fault;
   logic [2:0]       fault_code;
   logic [CNT_W-1:0] cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   traffic_conflict_monitor #(.MAX_DWELL(MAX_DWELL), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .modo        (modo),
      .A_green     (A_green),
      .A_yellow    (A_yellow),
      .A_red       (A_red),
      .B_green     (B_green),
      .B_yellow    (B_yellow),
      .B_red       (B_red),
      .clear_fault (clear_fault),
      .phase       (phase),
      .phase_valid (phase_valid),
      .fault       (fault),
      .fault_code  (fault_code),
      .cycle_count (cycle_count)
   );

   typedef struct {
      logic [5:0] lamps;
      bit         modo;
      bit         clr;
      int         ph;
      bit         pv;
      bit         flt;
      int         code;
      int         cnt;
   } vec_t;

   vec_t       vecs[$];
   logic [5:0] pat [6];
   bit         allowed [8][8];

   // Reference model state: rule-level view of the sample stream.
   bit         m_have, m_armed, m_faulted, m_modo_d, m_modo_dd, m_pvalid;
   logic [5:0] m_lamp_d;
   int         m_prev, m_run, m_code, m_cycles, m_phase;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input int ph, input bit pv, input bit f,
                                input int code, input int cnt);
      check({tag, " phase"}, 32'(phase), ph);
      check({tag, " phase_valid"}, 32'(phase_valid), 32'(pv));
      check({tag, " fault"}, 32'(fault), 32'(f));
      check({tag, " fault_code"}, 32'(fault_code), code);
      check({tag, " cycle_count"}, 32'(cycle_count), cnt);
   endtask

   function automatic void add(input logic [5:0] l, input bit m, input bit c, input int ph,
                               input bit pv, input bit f, input int code, input int cnt);
      vec_t v;
      v.lamps = l; v.modo = m; v.clr = c;
      v.ph = ph; v.pv = pv; v.flt = f; v.code = code; v.cnt = cnt;
      vecs.push_back(v);
   endfunction

   function automatic int classify(input logic [5:0] l);
      for (int k = 0; k < 6; k++) if (l == pat[k]) return k;
      return 7;
   endfunction

   function automatic bit conflict_of(input logic [5:0] l);
      logic [2:0] a, b;
      a = l[5:3];
      b = l[2:0];
      return ($countones(a) > 1) || ($countones(b) > 1) ||
             ((a[2] || a[1]) && (b[2] || b[1]) && (l != L_FL));
   endfunction

   task automatic model_reset();
      m_have = 0; m_armed = 0; m_faulted = 0; m_modo_d = 0; m_modo_dd = 0;
      m_pvalid = 0; m_lamp_d = '0; m_prev = 0; m_run = 0; m_code = 0;
      m_cycles = 0; m_phase = 0;
   endtask

   // Called once per clock edge with the inputs present at that edge.
   task automatic model_edge(input logic [5:0] l, input bit m, input bit c);
      int p, code;
      bit conf, mode_ok;
      if (m_have) begin
         p = classify(m_lamp_d);
         conf = conflict_of(m_lamp_d);
         m_phase = p;
         m_pvalid = (p != 7);
         if (m_faulted) begin
            if (c) begin m_faulted = 0; m_code = 0; m_armed = 0; end
         end else if (!m_armed) begin
            if (conf)          begin m_faulted = 1; m_code = 1; end
            else if (p == 7)   begin m_faulted = 1; m_code = 2; end
            else               begin m_armed = 1; m_prev = p; m_run = 1; end
         end else begin
            mode_ok = (p < 4) ? (m_modo_dd == 0) : (m_modo_dd == 1);
            if (conf)                                  code = 1;
            else if (p == 7)                           code = 2;
            else if (!allowed[m_prev][p])              code = 3;
            else if (!mode_ok)                         code = 5;
            else if (p == m_prev && m_run + 1 > MAX_DWELL) code = 4;
            else                                       code = 0;
            if (code != 0) begin
               m_faulted = 1;
               m_code = code;
            end else begin
               if (m_prev == 3 && p == 0) m_cycles = (m_cycles + 1) % (1 << CNT_W);
               m_run = (p == m_prev) ? m_run + 1 : 1;
               m_prev = p;
            end
         end
      end
      m_modo_dd = m_modo_d;
      m_modo_d  = m;
      m_lamp_d  = l;
      m_have    = 1;
   endtask

   task automatic drive(input logic [5:0] l, input bit m, input bit c);
      {A_green, A_yellow, A_red, B_green, B_yellow, B_red} = l;
      modo = m;
      clear_fault = c;
   endtask

   task automatic apply(input logic [5:0] l, input bit m, input bit c);
      @(negedge clk);
      drive(l, m, c);
      @(posedge clk);
      model_edge(l, m, c);
      #1;
   endtask

   // Release lands mid-cycle so the next apply() sees no extra edge.
   task automatic release_reset();
      @(posedge clk);
      #2 reset = 1'b1;
   endtask

   function automatic int succ(input int idx);
      if (idx < 4)  return (idx + 1) % 4;
      if (idx == 4) return 5;
      if (idx == 5) return 4;
      return 0;
   endfunction

   initial begin
      logic [5:0] rl;
      bit mr, rc;

      pat = '{L_AG, L_AY, L_BG, L_BY, L_FL, L_DK};
      for (int i = 0; i < 6; i++) allowed[i][i] = 1;
      allowed[0][1] = 1; allowed[1][2] = 1; allowed[2][3] = 1; allowed[3][0] = 1;
      allowed[4][5] = 1; allowed[5][4] = 1; allowed[4][0] = 1; allowed[5][0] = 1;
      for (int i = 0; i < 4; i++) allowed[i][4] = 1;

      // Day cycling, sequence fault, conflict, dwell limit, mode changes.
      add(L_AG, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         add(L_AY, 0, 0, 0, 1, 0, 0, k);
         add(L_BG, 0, 0, 1, 1, 0, 0, k);
         add(L_BY, 0, 0, 2, 1, 0, 0, k);
         add(L_AG, 0, 0, 3, 1, 0, 0, k);
      end
      add(L_AG, 0, 0, 0, 1, 0, 0, 3);
      add(L_BG, 0, 0, 0, 1, 0, 0, 3);
      add(L_AG, 0, 0, 2, 1, 1, 3, 3);
      add(L_AG, 0, 1, 0, 1, 0, 0, 3);
      add(L_AY, 0, 0, 0, 1, 0, 0, 3);
      add(L_AY, 0, 0, 1, 1, 0, 0, 3);
      add(L_BG, 0, 0, 1, 1, 0, 0, 3);
      add(L_BY, 0, 0, 2, 1, 0, 0, 3);
      add(L_CF, 0, 0, 3, 1, 0, 0, 3);
      add(L_AG, 0, 0, 7, 0, 1, 1, 3);
      add(L_AG, 0, 0, 0, 1, 1, 1, 3);
      add(L_AG, 0, 1, 0, 1, 0, 0, 3);
      for (int k = 0; k < 7; k++) add(L_AG, 0, 0, 0, 1, 0, 0, 3);
      add(L_AY, 0, 0, 0, 1, 0, 0, 3);
      add(L_BG, 0, 0, 1, 1, 0, 0, 3);
      for (int k = 0; k < 8; k++) add(L_BG, 0, 0, 2, 1, 0, 0, 3);
      add(L_BG, 0, 0, 2, 1, 1, 4, 3);
      add(L_BG, 0, 1, 2, 1, 0, 0, 3);
      add(L_BY, 0, 0, 2, 1, 0, 0, 3);
      add(L_AG, 0, 0, 3, 1, 0, 0, 3);
      add(L_AY, 0, 0, 0, 1, 0, 0, 4);
      add(L_AY, 1, 0, 1, 1, 0, 0, 4);
      add(L_FL, 1, 0, 1, 1, 0, 0, 4);
      add(L_DK, 1, 0, 4, 1, 0, 0, 4);
      add(L_FL, 1, 0, 5, 1, 0, 0, 4);
      add(L_FL, 0, 0, 4, 1, 0, 0, 4);
      add(L_FL, 0, 0, 4, 1, 0, 0, 4);
      add(L_FL, 0, 0, 4, 1, 1, 5, 4);
      add(L_AG, 0, 1, 4, 1, 0, 0, 4);
      add(L_CF, 0, 0, 0, 1, 0, 0, 4);
      add(L_AG, 0, 0, 7, 0, 1, 1, 4);

      reset = 1'b0;
      drive(L_DK, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset", 0, 0, 0, 0, 0);
      release_reset();

      foreach (vecs[i]) begin
         apply(vecs[i].lamps, vecs[i].modo, vecs[i].clr);
         check_outputs($sformatf("row%0d", i + 1), vecs[i].ph, vecs[i].pv, vecs[i].flt,
                       vecs[i].code, vecs[i].cnt);
      end

      // Fault code 1 is latched here; reset asynchronously mid-cycle.
      #3 reset = 1'b0;
      #1;
      check_outputs("async_reset", 0, 0, 0, 0, 0);
      drive(L_BG, 0, 0);
      model_reset();
      release_reset();
      apply(L_BG, 0, 0);
      check_outputs("post_reset_capture", 0, 0, 0, 0, 0);
      apply(L_BG, 0, 0);
      check_outputs("post_reset_first", 2, 1, 0, 0, 0);
      apply(L_BY, 0, 0);
      check_outputs("post_reset_hold", 2, 1, 0, 0, 0);
      apply(L_AY, 0, 0);
      check_outputs("post_reset_by", 3, 1, 0, 0, 0);
      apply(L_AY, 0, 0);
      check_outputs("post_reset_run_seq", 1, 1, 1, 3, 0);

      // Randomized lamps, mode and clears against the reference model.
      reset = 1'b0;
      rl = L_AG; mr = 1'b0; rc = 1'b0;
      drive(rl, mr, rc);
      model_reset();
      #7;
      release_reset();
      for (int i = 0; i < 4000; i++) begin
         int r, r2, hold_pct;
         hold_pct = (i < 2000) ? 45 : 85;
         r = $urandom_range(0, 99);
         if (r >= hold_pct) begin
            r2 = $urandom_range(0, 99);
            if (r2 < 60)      rl = pat[succ(classify(rl))];
            else if (r2 < 85) rl = pat[$urandom_range(0, 5)];
            else              rl = 6'($urandom);
         end
         if ($urandom_range(0, 29) == 0) mr = ~mr;
         rc = ($urandom_range(0, 9) == 0);
         apply(rl, mr, rc);
         check_outputs("rand", m_phase, m_pvalid, m_faulted, m_code, m_cycles);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
